// File: rtl/dmrs_re_mapper.sv
// DMRS resource-element mapper: buffers one DMRS sequence and emits a
// full IFFT-ordered symbol frame with zeros outside the allocation.
module dmrs_re_mapper #(
    parameter int FFT_SIZE = 2048,
    parameter int MAX_SC   = 1200,
    parameter int AW       = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [6:0]          N_rb,
    input  logic [AW-1:0]       k_start,
    input  logic signed [8:0]   DMRS_r,
    input  logic signed [8:0]   DMRS_i,
    input  logic                DMRS_valid,
    input  logic                out_ready,
    output logic signed [8:0]   out_r,
    output logic signed [8:0]   out_i,
    output logic                out_valid,
    output logic                out_last,
    output logic                busy,
    output logic                cfg_err
);

    localparam int MW = 11;
    localparam int BA = (MAX_SC > 1) ? $clog2(MAX_SC) : 1;
    localparam int WW = ((AW + 1 > MW) ? AW + 1 : MW) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [17:0]   r_mem [MAX_SC];
    logic [17:0]   r_q;

    logic [MW-1:0] r_m;
    logic [AW-1:0] r_k;
    logic [WW-1:0] r_end;
    logic [MW-1:0] r_wr_cnt;
    logic [AW-1:0] r_n;
    logic          r_fetch_done;
    logic          r_p1_valid;
    logic          r_p1_inr;
    logic          r_p1_last;

    logic [MW-1:0] w_m;
    logic [WW-1:0] w_end;
    logic          w_cfg_bad;
    logic          w_start_ok;
    logic          w_load_last;
    logic          w_en;
    logic          w_fetch;
    logic [AW-1:0] w_fetch_n;
    logic          w_in_rng;
    logic [AW-1:0] w_off;
    logic [BA-1:0] w_rd_addr;
    logic [BA-1:0] w_wr_addr;
    logic          w_last_hs;

    assign w_m   = MW'(N_rb) * MW'(12);
    assign w_end = WW'(k_start) + WW'(w_m);

    assign w_cfg_bad = (N_rb == 7'd0) || (N_rb > 7'd100)
                    || (w_end > WW'(FFT_SIZE))
                    || (w_m > MW'(MAX_SC));

    assign w_start_ok  = (r_state == S_IDLE) && start && !w_cfg_bad;
    assign w_load_last = (r_state == S_LOAD) && DMRS_valid
                      && (r_wr_cnt == r_m - MW'(1));

    // Output stage advances when empty or being accepted.
    assign w_en      = !out_valid || out_ready;
    assign w_last_hs = out_valid && out_ready && out_last;

    // Bin 0 is fetched in the final LOAD cycle to hit the 2-cycle latency.
    assign w_fetch = w_load_last
                  || ((r_state == S_EMIT) && w_en && !r_fetch_done);
    assign w_fetch_n = w_load_last ? '0 : r_n;

    assign w_in_rng = (WW'(w_fetch_n) >= WW'(r_k))
                   && (WW'(w_fetch_n) < r_end);
    assign w_off     = w_fetch_n - r_k;
    assign w_rd_addr = BA'(w_off);
    assign w_wr_addr = BA'(r_wr_cnt);

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_ok)  w_next = S_LOAD;
            S_LOAD: if (w_load_last) w_next = S_EMIT;
            S_EMIT: if (w_last_hs)   w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_LOAD) && DMRS_valid) begin
            r_mem[w_wr_addr] <= {DMRS_r, DMRS_i};
        end
        if (w_fetch && w_in_rng) begin
            r_q <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err      <= 1'b0;
            r_m          <= '0;
            r_k          <= '0;
            r_end        <= '0;
            r_wr_cnt     <= '0;
            r_n          <= '0;
            r_fetch_done <= 1'b0;
            r_p1_valid   <= 1'b0;
            r_p1_inr     <= 1'b0;
            r_p1_last    <= 1'b0;
            out_r        <= '0;
            out_i        <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                cfg_err <= w_cfg_bad;
            end
            if (w_start_ok) begin
                r_m      <= w_m;
                r_k      <= k_start;
                r_end    <= w_end;
                r_wr_cnt <= '0;
            end else if ((r_state == S_LOAD) && DMRS_valid) begin
                r_wr_cnt <= r_wr_cnt + MW'(1);
            end

            if (w_load_last) begin
                r_n          <= AW'(1);
                r_fetch_done <= (FFT_SIZE == 1);
            end else if (w_fetch) begin
                r_n <= r_n + AW'(1);
                if (r_n == AW'(FFT_SIZE - 1)) begin
                    r_fetch_done <= 1'b1;
                end
            end

            if (w_en) begin
                r_p1_valid <= w_fetch;
                r_p1_inr   <= w_fetch && w_in_rng;
                r_p1_last  <= w_fetch
                           && (w_fetch_n == AW'(FFT_SIZE - 1));
                out_valid  <= r_p1_valid;
                out_last   <= r_p1_last;
                out_r      <= r_p1_inr ? r_q[17:9] : 9'sd0;
                out_i      <= r_p1_inr ? r_q[8:0]  : 9'sd0;
            end
        end
    end

endmodule

// File: tb/tb_dmrs_re_mapper.sv
// Scoreboard bench for dmrs_re_mapper: a frame model fills an expected
// queue, a monitor pops it on every output handshake.
module tb_dmrs_re_mapper;

    localparam int FFT = 64;
    localparam int AW  = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [6:0]          N_rb = '0;
    logic [AW-1:0]       k_start = '0;
    logic signed [8:0]   DMRS_r = '0;
    logic signed [8:0]   DMRS_i = '0;
    logic                DMRS_valid = 1'b0;
    logic                out_ready = 1'b1;
    logic signed [8:0]   out_r;
    logic signed [8:0]   out_i;
    logic                out_valid;
    logic                out_last;
    logic                busy;
    logic                cfg_err;

    dmrs_re_mapper #(
        .FFT_SIZE (FFT),
        .MAX_SC   (1200),
        .AW       (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .N_rb       (N_rb),
        .k_start    (k_start),
        .DMRS_r     (DMRS_r),
        .DMRS_i     (DMRS_i),
        .DMRS_valid (DMRS_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int i;
        int last;
    } exp_t;

    exp_t q[$];
    int   sr[$];
    int   si[$];
    int   errors = 0;
    int   checks = 0;
    int   bins_seen = 0;
    int   rdy_mode = 0;
    int   stall_cnt = 0;
    bit   stall_done = 1'b0;

    bit   hold = 1'b0;
    int   hr, hi, hv, hl;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference frame: bin n carries sample n-k inside [k, k+m), else zero.
    task automatic push_frame(input int k, input int m);
        for (int n = 0; n < FFT; n++) begin
            exp_t e;
            if (n >= k && n < k + m) begin
                e.r = sr[n - k];
                e.i = si[n - k];
            end else begin
                e.r = 0;
                e.i = 0;
            end
            e.last = (n == FFT - 1) ? 1 : 0;
            q.push_back(e);
        end
    endtask

    task automatic seq_ramp();
        sr.delete();
        si.delete();
        for (int s = 1; s <= 12; s++) begin
            sr.push_back(s);
            si.push_back(-s);
        end
    endtask

    task automatic seq_rand(input int m);
        sr.delete();
        si.delete();
        for (int s = 0; s < m; s++) begin
            sr.push_back(int'($urandom_range(0, 511)) - 256);
            si.push_back(int'($urandom_range(0, 511)) - 256);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_r", out_r, hr);
                chk("hold_i", out_i, hi);
                chk("hold_valid", out_valid, hv);
                chk("hold_last", out_last, hl);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got r=%0d i=%0d required none",
                             out_r, out_i);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_r", out_r, e.r);
                    chk("out_i", out_i, e.i);
                    chk("out_last", out_last, e.last);
                end
                bins_seen++;
            end
            hold = out_valid && !out_ready;
            hr = out_r;
            hi = out_i;
            hv = out_valid;
            hl = out_last;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            out_ready = 1'b1;
        end else if (!stall_done && bins_seen == 10 && out_valid) begin
            out_ready = 1'b0;
            stall_cnt++;
            if (stall_cnt >= 10) stall_done = 1'b1;
        end else begin
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic do_start(input int nrb, input int k);
        @(posedge clk);
        #1;
        start   = 1'b1;
        N_rb    = 7'(nrb);
        k_start = AW'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input bit gap, input bit pulse);
        for (int n = 0; n < sr.size(); n++) begin
            if (gap && (n % 3) == 2) begin
                DMRS_valid = 1'b0;
                if (pulse) begin
                    start   = 1'b1;
                    N_rb    = 7'($urandom_range(1, 5));
                    k_start = AW'($urandom_range(0, 3));
                end
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            DMRS_valid = 1'b1;
            DMRS_r = 9'(sr[n]);
            DMRS_i = 9'(si[n]);
            @(posedge clk);
            #1;
        end
        DMRS_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_t2_valid", out_valid, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d bins left required 0",
                     q.size());
            q.delete();
        end else begin
            #1;
            chk("busy_after", busy, 0);
            chk("valid_after", out_valid, 0);
        end
    endtask

    task automatic frame(input int nrb, input int k,
                         input bit ramp, input bit gap, input bit pulse);
        if (ramp) seq_ramp();
        else      seq_rand(12 * nrb);
        bins_seen = 0;
        do_start(nrb, k);
        chk("cfg_ok", cfg_err, 0);
        chk("busy_load", busy, 1);
        push_frame(k, 12 * nrb);
        send(gap, pulse);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg", cfg_err, 0);
        chk("rst_r", out_r, 0);
        reset = 1'b1;

        frame(1, 4, 1'b1, 1'b0, 1'b0);
        wait_done();

        frame(5, 4, 1'b0, 1'b0, 1'b0);
        wait_done();

        do_start(6, 0);
        chk("err_m72", cfg_err, 1);
        chk("err_busy", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("err_novalid", out_valid, 0);
        chk("err_idle", busy, 0);
        do_start(0, 4);
        chk("err_nrb0", cfg_err, 1);
        chk("err_busy0", busy, 0);
        do_start(1, 60);
        chk("err_ovf", cfg_err, 1);

        frame(5, 4, 1'b0, 1'b0, 1'b0);
        wait_done();

        rdy_mode = 1;
        stall_cnt = 0;
        stall_done = 1'b0;
        frame(1, 4, 1'b1, 1'b0, 1'b0);
        wait_done();
        chk("stall_seen", stall_done, 1);
        rdy_mode = 0;

        frame(5, 4, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b1;
        N_rb = 7'd2;
        k_start = AW'(0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        frame(2, 0, 1'b0, 1'b0, 1'b0);
        wait_done();

        frame(1, 4, 1'b1, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (bins_seen < 20 && n < 500) begin
                @(posedge clk);
                n++;
            end
            chk("reach_bin20", (bins_seen >= 20) ? 1 : 0, 1);
        end
        #1;
        reset = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_r", out_r, 0);
        chk("abort_last", out_last, 0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;

        frame(1, 4, 1'b1, 1'b0, 1'b0);
        wait_done();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
